// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction/data memory request/acknowledge bundle for cpu_sequencer
interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [8:0]          imem_rdata;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/writeback control sequencer
// Optional acknowledge watchdog enabled by defining SEQ_WATCHDOG_EN.
module cpu_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int WD_LIMIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  cpu_sequencer_if.master     mem,
  output logic [8:0]          instr,
  input  logic                dec_mem_read,
  input  logic                dec_mem_write,
  input  logic                dec_reg_write,
  input  logic                dec_car_write,
  input  logic                dec_halt,
  input  logic                jump,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                reg_we,
  output logic                car_we,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [8:0]          instr_q, instr_d;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = (WD_LIMIT > 1) ? $clog2(WD_LIMIT + 1) : 1;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            fault_q, fault_d;
  logic            waiting;

  assign waiting = ((state_q == S_FETCH) && !mem.imem_ack) ||
                   ((state_q == S_MEM)   && !mem.dmem_ack);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef SEQ_WATCHDOG_EN
    wd_d    = wd_q;
    fault_d = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem.imem_ack) begin
          instr_d = mem.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem.dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        // Jump has priority over a taken branch; otherwise fall through with natural wrap.
        if (jump)              pc_d = jump_target;
        else if (branch_taken) pc_d = branch_target;
        else                   pc_d = pc_q + 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
`ifdef SEQ_WATCHDOG_EN
          fault_d = 1'b0;
`endif
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SEQ_WATCHDOG_EN
    // The limit-th consecutive unacknowledged cycle gives up and parks in HALT.
    if (waiting) begin
      if (wd_q == WD_W'(WD_LIMIT - 1)) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wd_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
`ifdef SEQ_WATCHDOG_EN
      wd_q    <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef SEQ_WATCHDOG_EN
      wd_q    <= wd_d;
      fault_q <= fault_d;
`endif
    end
  end

  // Requests and strobes decode straight from state so async reset drops them at once.
  assign mem.imem_req  = (state_q == S_FETCH);
  assign mem.imem_addr = pc_q;
  assign mem.dmem_req  = (state_q == S_MEM);
  assign mem.dmem_we   = (state_q == S_MEM) && dec_mem_write;
  assign reg_we        = (state_q == S_WB) && dec_reg_write;
  assign car_we        = (state_q == S_WB) && dec_car_write;
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted        = (state_q == S_HALT);

`ifdef SEQ_WATCHDOG_EN
  assign fault = fault_q;
`else
  // WD_LIMIT has no effect without the watchdog.
  assign fault = 1'b0 & (WD_LIMIT > 0);
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] instr;
  logic       dec_mem_read = 1'b0, dec_mem_write = 1'b0, dec_reg_write = 1'b0;
  logic       dec_car_write = 1'b0, dec_halt = 1'b0;
  logic       jump = 1'b0, branch_taken = 1'b0;
  logic [7:0] jump_target = 8'h00, branch_target = 8'h00;
  logic       reg_we, car_we, busy, halted, fault;
  logic [7:0] pc;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] fetch_q[$];
  logic [1:0] strobe_q[$];
  logic       dmem_q[$];
  logic [7:0] exp_pc = 8'h00;
  bit         prev_ireq = 1'b0, prev_dreq = 1'b0;

  cpu_sequencer_if #(.PC_WIDTH(8)) mem_if ();

  cpu_sequencer #(.PC_WIDTH(8), .WD_LIMIT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mem           (mem_if.master),
    .instr         (instr),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .dec_reg_write (dec_reg_write),
    .dec_car_write (dec_car_write),
    .dec_halt      (dec_halt),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .reg_we        (reg_we),
    .car_we        (car_we),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: unexpected event with value %0h, nothing expected", nm, act);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a request or strobe.
  always @(negedge clk) begin
    if (mem_if.imem_req && !prev_ireq) begin
      if (fetch_q.size() == 0) unexpected("fetch", 32'(mem_if.imem_addr));
      else check("fetch addr", 32'(mem_if.imem_addr), 32'(fetch_q.pop_front()));
    end
    if (mem_if.dmem_req && !prev_dreq) begin
      if (dmem_q.size() == 0) unexpected("dmem", 32'(mem_if.dmem_we));
      else check("dmem_we", 32'(mem_if.dmem_we), 32'(dmem_q.pop_front()));
    end
    if (reg_we || car_we) begin
      if (strobe_q.size() == 0) unexpected("strobe", 32'({reg_we, car_we}));
      else check("reg_we/car_we", 32'({reg_we, car_we}), 32'(strobe_q.pop_front()));
    end
    prev_ireq = mem_if.imem_req;
    prev_dreq = mem_if.dmem_req;
  end

  task automatic wait_fetch();
    int k = 0;
    while (!mem_if.imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("fetch reached", 32'(mem_if.imem_req), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one instruction from its FETCH cycle until the next FETCH (or HALT).
  task automatic run_instr(input string nm, input logic [8:0] rdata,
                           input bit mr, input bit wr, input bit rw, input bit cw,
                           input bit hlt, input bit jmp, input bit br,
                           input logic [7:0] jt, input logic [7:0] bt,
                           input int fw, input int mwait, input bit poke);
    int cyc, dcyc, fcnt, mcnt, strobe_at, exp_lat;
    bit fetched, done, is_mem;
    logic [7:0] nxt;
    cyc = 0; dcyc = 0; fcnt = 0; mcnt = 0; strobe_at = -1;
    fetched = 1'b0; done = 1'b0; is_mem = mr | wr;
    dec_mem_read = mr; dec_mem_write = wr; dec_reg_write = rw;
    dec_car_write = cw; dec_halt = hlt;
    jump = jmp; branch_taken = br; jump_target = jt; branch_target = bt;
    exp_lat = fw + (hlt ? 2 : (is_mem ? 5 + mwait : 4));
    if (!hlt) begin
      if (rw | cw) strobe_q.push_back({rw, cw});
      if (is_mem) dmem_q.push_back(wr);
      nxt = jmp ? jt : (br ? bt : exp_pc + 8'd1);
      fetch_q.push_back(nxt);
      exp_pc = nxt;
    end
    for (int k = 0; k < 200 && !done; k++) begin
      mem_if.imem_ack = 1'b0;
      mem_if.dmem_ack = 1'b0;
      start = 1'b0;
      if (fetched && (mem_if.imem_req || halted)) begin
        done = 1'b1;
      end else begin
        if (mem_if.imem_req) begin
          if (fcnt == fw) begin
            mem_if.imem_ack   = 1'b1;
            mem_if.imem_rdata = rdata;
            fetched = 1'b1;
          end else fcnt++;
        end
        if (mem_if.dmem_req) begin
          dcyc++;
          if (mcnt == mwait) mem_if.dmem_ack = 1'b1;
          else mcnt++;
        end
        if (reg_we || car_we) strobe_at = cyc;
        if (poke && fetched) start = 1'b1;
        cyc++;
        @(negedge clk);
      end
    end
    check({nm, " completed"}, 32'(done), 32'd1);
    check({nm, " latency"}, 32'(cyc), 32'(exp_lat));
    if (is_mem && !hlt) check({nm, " dmem_req cycles"}, 32'(dcyc), 32'(mwait + 1));
    if ((rw | cw) && !hlt) check({nm, " strobe cycle"}, 32'(strobe_at), 32'(exp_lat - 1));
    check({nm, " pc"}, 32'(pc), 32'(exp_pc));
    check({nm, " instr"}, 32'(instr), 32'(rdata));
    if (hlt) begin
      check({nm, " halted"}, 32'(halted), 32'd1);
      check({nm, " busy"}, 32'(busy), 32'd0);
      check({nm, " reg_we"}, 32'(reg_we), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    mem_if.imem_ack   = 1'b0;
    mem_if.dmem_ack   = 1'b0;
    mem_if.imem_rdata = 9'h000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst imem_req", 32'(mem_if.imem_req), 32'd0);
    check("rst dmem_req", 32'(mem_if.dmem_req), 32'd0);
    check("rst dmem_we", 32'(mem_if.dmem_we), 32'd0);
    check("rst imem_addr", 32'(mem_if.imem_addr), 32'd0);
    check("rst pc", 32'(pc), 32'd0);
    check("rst instr", 32'(instr), 32'd0);
    check("rst strobes", 32'({reg_we, car_we}), 32'd0);
    check("rst busy/halted/fault", 32'({busy, halted, fault}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle without start", 32'(busy), 32'd0);

    fetch_q.push_back(8'h00);
    pulse_start();
    wait_fetch();
    run_instr("ADD", 9'b010_01_10_11, 0, 0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    run_instr("LW",  9'h0C5, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 3, 1);
    run_instr("SW",  9'h0E6, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    run_instr("BEQ", 9'h1C3, 0, 0, 0, 1, 0, 0, 1, 8'h00, 8'h40, 0, 0, 0);
    run_instr("JR",  9'h1E0, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 8'h00, 0, 0, 1);
    run_instr("WRAP", 9'h011, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 2, 0, 0);
    run_instr("JMPBR", 9'h1F2, 0, 0, 0, 0, 0, 1, 1, 8'h20, 8'h40, 0, 0, 0);
    run_instr("HALT", 9'h1FF, 0, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Restart from HALT
    dec_halt = 1'b0;
    fetch_q.push_back(8'h00);
    exp_pc = 8'h00;
    pulse_start();
    wait_fetch();
    check("restart pc", 32'(pc), 32'd0);
    check("restart busy/halted", 32'({busy, halted}), 32'b10);

    // Reset while a load is waiting in MEM
    dec_mem_read = 1'b1; dec_mem_write = 1'b0; dec_reg_write = 1'b1;
    dec_car_write = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    dmem_q.push_back(1'b0);
    mem_if.imem_ack = 1'b1;
    mem_if.imem_rdata = 9'h1A5;
    @(negedge clk);
    mem_if.imem_ack = 1'b0;
    k = 0;
    while (!mem_if.dmem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("mem reached", 32'(mem_if.dmem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async drop dmem_req", 32'(mem_if.dmem_req), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset pc/instr", 32'({pc, instr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_if.dmem_ack = 1'b1;
    mem_if.imem_ack = 1'b1;
    @(negedge clk);
    mem_if.dmem_ack = 1'b0;
    mem_if.imem_ack = 1'b0;
    @(negedge clk);
    check("late ack ignored", 32'({busy, mem_if.imem_req, mem_if.dmem_req, halted}), 32'd0);
    check("late ack pc", 32'(pc), 32'd0);
    exp_pc = 8'h00;

    fetch_q.push_back(8'h00);
    pulse_start();
    wait_fetch();
    run_instr("ADD2", 9'b010_01_10_11, 0, 0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Fetch never acknowledged
`ifdef SEQ_WATCHDOG_EN
    k = 0;
    while (!halted && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("watchdog wait cycles", 32'(k), 32'd15);
    check("watchdog fault", 32'(fault), 32'd1);
    check("watchdog busy", 32'(busy), 32'd0);
    fetch_q.push_back(8'h00);
    exp_pc = 8'h00;
    pulse_start();
    wait_fetch();
    check("fault cleared by start", 32'(fault), 32'd0);
    check("pc after fault restart", 32'(pc), 32'd0);
`else
    repeat (100) @(negedge clk);
    check("stall still fetching", 32'(mem_if.imem_req), 32'd1);
    check("stall no halt/fault", 32'({halted, fault}), 32'd0);
    check("stall pc", 32'(pc), 32'(exp_pc));
`endif

    @(negedge clk);
    check("fetch queue drained", 32'(fetch_q.size()), 32'd0);
    check("strobe queue drained", 32'(strobe_q.size()), 32'd0);
    check("dmem queue drained", 32'(dmem_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: PC_WIDTH, default 8, program-counter and instruction-address width.
REQ-002 Parameter: WD_LIMIT, default 15, maximum wait cycles for a memory acknowledge (used only with the watchdog).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  start/restart pulse.
REQ-006 imem_req  output  1  instruction fetch request; imem_addr  output  PC_WIDTH  fetch address.
REQ-007 imem_ack  input  1  fetch done; imem_rdata  input  9  instruction word.
REQ-008 dmem_req  output  1  data access request; dmem_we  output  1  1=store, 0=load; dmem_ack  input  1  access done.
REQ-009 instr  output  9  instruction register, to decoder.
REQ-010 dec_mem_read, dec_mem_write, dec_reg_write, dec_car_write, dec_halt  input  1 each  decoder controls for instr.
REQ-011 jump, branch_taken  input  1 each  JR and BEQ resolution; jump_target, branch_target  input  PC_WIDTH each.
REQ-012 reg_we, car_we  output  1 each  single-cycle register-file and carry write strobes.
REQ-013 pc  output  PC_WIDTH  current PC; busy  output  1  state not IDLE/HALT; halted  output  1  in HALT; fault  output  1  watchdog fired.

Function
REQ-014 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; one-hot or binary at implementer's choice.
REQ-015 IDLE: start=1 -> FETCH next cycle; pc unchanged.
REQ-016 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1 -> instr<=imem_rdata, -> DECODE; imem_ack in any other state ignored.
REQ-017 DECODE: one cycle; dec_halt=1 -> HALT, else -> EXEC.
REQ-018 EXEC: one cycle; dec_mem_read|dec_mem_write -> MEM, else -> WB.
REQ-019 MEM: dmem_req=1, dmem_we=dec_mem_write (write wins if both asserted); on dmem_ack=1 -> WB; dmem_ack outside MEM ignored.
REQ-020 WB: reg_we=dec_reg_write, car_we=dec_car_write, exactly one cycle; pc<=jump_target if jump, else branch_target if branch_taken, else pc+1 modulo 2^PC_WIDTH (all-ones wraps to 0); -> FETCH.
REQ-021 Latency: non-memory instruction = 4 cycles from FETCH entry with zero-wait ack (FETCH, DECODE, EXEC, WB); memory instruction = 5 + wait cycles.
REQ-022 HALT: halted=1, all requests and strobes 0; start=1 -> pc<=0, fault<=0, -> FETCH.
REQ-023 start while busy=1 ignored.
REQ-024 imem_req/dmem_req held high until ack; request outputs, reg_we, car_we decoded combinationally from state (no extra cycle).

Reset
REQ-025 rst_n=0 asynchronously forces IDLE, pc=0, instr=0, fault=0, watchdog counter=0; all outputs 0 except imem_addr=0.
REQ-026 Reset mid-FETCH/MEM drops imem_req/dmem_req immediately, without waiting for a clock edge; a late ack after release is ignored (state IDLE).

Configuration
REQ-027 Macro SEQ_WATCHDOG_EN defined: counter clears on FETCH/MEM entry, increments each waiting cycle; when it reaches WD_LIMIT with no ack -> HALT, fault=1 (sticky until start or reset).
REQ-028 SEQ_WATCHDOG_EN undefined: no counter, waits indefinitely, fault tied 0, WD_LIMIT unused.

Verification
REQ-029 Reset, start, imem_rdata=9'b010_01_10_11 (ADD), zero-wait ack, dec_reg_write=dec_car_write=1 -> reg_we and car_we high one cycle 4 cycles after FETCH entry; pc 0->1.
REQ-030 LW (dec_mem_read=1), dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, reg_we pulse next cycle, pc+1.
REQ-031 pc=8'hFF, non-branch instruction -> pc=8'h00 after WB; jump=1 with branch_taken=1, jump_target=8'h20, branch_target=8'h40 -> pc=8'h20.
REQ-032 dec_halt=1 -> halted=1, busy=0, no reg_we; start -> pc=0, FETCH with imem_req=1.
REQ-033 rst_n low during MEM with dmem_req=1 -> dmem_req=0 before next edge, state IDLE, pc=0; ack pulse afterwards has no effect.
REQ-034 SEQ_WATCHDOG_EN, WD_LIMIT=15, imem_ack never asserted -> HALT with fault=1 after 15 waiting cycles; without the macro -> still FETCH after 100 cycles, fault=0.
